rle_row_decompressor: RTL and testbench



---
 rtl/rle_row_decompressor.sv | 94 +++++++++
 tb/tb_rle_row_decompressor.sv | 130 +++++++++++++
 2 files changed

// File: rtl/rle_row_decompressor.sv
// rle_row_decompressor: rebuilds a feature-map row from alternating run-length sections
// Each section is decoded in one cycle; the row may span several input words.
module rle_row_decompressor #(
    parameter int SECTION_SIZE = 4,
    parameter int WORD_SIZE    = 16,
    parameter int ROW_SIZE     = 16,
    parameter bit START_VALUE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROW_SIZE-1:0]  out_data,
    output logic                 out_error,
    output logic                 busy
);
    localparam int CNT_W = $clog2(ROW_SIZE + 1);
    localparam int CW    = CNT_W + 1;

    typedef enum logic [1:0] {WAIT_WORD, DECODE, EMIT} state_t;

    state_t                state, state_n;
    logic [ROW_SIZE-1:0]   row, row_n;
    logic [CNT_W-1:0]      total;
    logic                  value, err, last_reg;
    logic [WORD_SIZE-1:0]  shreg, shreg_n;
    logic [SECTION_SIZE-1:0] n;
    logic [CW-1:0]         sum, end_pos;
    logic                  ovf, word_end;

    always_comb begin
        n        = shreg[SECTION_SIZE-1:0];
        sum      = CW'(total) + CW'(n);
        ovf      = sum > CW'(ROW_SIZE);
        end_pos  = ovf ? CW'(ROW_SIZE) : sum;
        shreg_n  = shreg >> SECTION_SIZE;
        word_end = shreg_n == '0;
        row_n    = row;
        // row is cleared at row start, so only 1-runs need to write
        for (int i = 0; i < ROW_SIZE; i++)
            if (value && CW'(i) >= CW'(total) && CW'(i) < end_pos) row_n[i] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= WAIT_WORD;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            WAIT_WORD: state_n = in_valid ? DECODE : WAIT_WORD;
            DECODE:    state_n = word_end ? (last_reg ? EMIT : WAIT_WORD) : DECODE;
            EMIT:      state_n = out_ready ? WAIT_WORD : EMIT;
            default:   state_n = WAIT_WORD;
        endcase
    end

    always_comb begin
        in_ready  = state == WAIT_WORD;
        out_valid = state == EMIT;
        busy      = state != WAIT_WORD;
        out_data  = row;
        out_error = err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row      <= '0;
            total    <= '0;
            value    <= START_VALUE;
            err      <= 1'b0;
            shreg    <= '0;
            last_reg <= 1'b0;
        end else if (state == WAIT_WORD && in_valid) begin
            shreg    <= in_data;
            last_reg <= in_last;
        end else if (state == DECODE) begin
            row      <= row_n;
            total    <= end_pos[CNT_W-1:0];
            value    <= ~value;
            err      <= err | ovf;
            shreg    <= shreg_n;
        end else if (state == EMIT && out_ready) begin
            row      <= '0;
            total    <= '0;
            value    <= START_VALUE;
            err      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rle_row_decompressor.sv
// tb_rle_row_decompressor: directed checks of the run-length row decompressor
module tb_rle_row_decompressor;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_data;
    logic        out_valid, out_ready, out_error, busy;
    logic [15:0] out_data;
    int          checks = 0;
    int          errors = 0;

    rle_row_decompressor dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_error(out_error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        chk("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    task automatic take_row(input string tag, input logic [15:0] d, input logic e);
        int k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_err"}, out_error, e);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ready_after"}, in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_error", out_error, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // 4,4,3: three decode cycles, out_valid on the third edge after accept
        send(16'h0344, 1'b1);
        chk("t1_busy", busy, 1);
        tick(); tick();
        chk("t1_valid_early", out_valid, 0);
        tick();
        chk("t1_valid_lat", out_valid, 1);
        chk("t1_in_ready_emit", in_ready, 0);
        take_row("t1", 16'h00F0, 1'b0);

        send(16'h0530, 1'b1);
        take_row("t2", 16'h0007, 1'b0);

        send(16'h0004, 1'b0);
        tick();
        chk("t3_ready_between", in_ready, 1);
        chk("t3_no_valid", out_valid, 0);
        send(16'h0008, 1'b1);
        take_row("t3", 16'h0FF0, 1'b0);

        send(16'h00FF, 1'b1);
        take_row("t4", 16'h8000, 1'b1);

        // backpressure: row held stable while out_ready is low
        send(16'h0344, 1'b1);
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_data", out_data, 16'h00F0);
            chk("t5_hold_err", out_error, 0);
            chk("t5_hold_in_ready", in_ready, 0);
            tick();
        end
        take_row("t5", 16'h00F0, 1'b0);

        // reset in the second decode cycle discards the partial row
        send(16'h0344, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        chk("t6_rst_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_stale", out_valid, 0);
        end
        send(16'h0002, 1'b1);
        take_row("t6", 16'h0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
